// File: rtl/datapath_cmd_sequencer.sv
// Command stage for the datapath: captures host commands written over the logic analyzer,
// queues them in a small show-ahead FIFO and issues them over a valid/ready handshake.
module datapath_cmd_sequencer #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic [127:0]      la_data_in,
    input  logic [127:0]      la_oenb,
    output logic [127:0]      la_data_out,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [2:0]        cmd_op,
    output logic [ADDR_W-1:0] cmd_rd,
    output logic [ADDR_W-1:0] cmd_rs1,
    output logic [ADDR_W-1:0] cmd_rs2,
    output logic [DATA_W-1:0] cmd_imm
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int RD_LSB  = DATA_W;
    localparam int RS1_LSB = RD_LSB + ADDR_W;
    localparam int RS2_LSB = RS1_LSB + ADDR_W;
    localparam int OP_LSB  = RS2_LSB + ADDR_W;

    typedef struct packed {
        logic [2:0]        op;
        logic [ADDR_W-1:0] rd;
        logic [ADDR_W-1:0] rs1;
        logic [ADDR_W-1:0] rs2;
        logic [DATA_W-1:0] imm;
    } entry_t;

    entry_t             mem [FIFO_DEPTH];
    entry_t             new_entry;
    entry_t             head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic [15:0]        issue_cnt;
    logic [15:0]        issue_next;
    logic               strb_q;
    logic               armed;
    logic               ovf_sticky;
    logic               ill_sticky;
    logic               ovf_next;
    logic               ill_next;
    logic               detect;
    logic               pop;
    logic               push_req;
    logic               push;
    logic               clr;
    logic [2:0]         op_in;
    logic [127:0]       status_next;
    logic               unused_bits;

    assign unused_bits = ^{la_oenb[126:0], la_data_in[126:OP_LSB+3]};

    always_comb begin
        new_entry     = '0;
        new_entry.op  = la_data_in[OP_LSB +: 3];
        new_entry.rd  = la_data_in[RD_LSB +: ADDR_W];
        new_entry.rs1 = la_data_in[RS1_LSB +: ADDR_W];
        new_entry.rs2 = la_data_in[RS2_LSB +: ADDR_W];
        new_entry.imm = la_data_in[DATA_W-1:0];
    end

    assign head      = mem[rd_ptr];
    assign cmd_valid = (count != '0);
    assign cmd_op    = cmd_valid ? head.op  : '0;
    assign cmd_rd    = cmd_valid ? head.rd  : '0;
    assign cmd_rs1   = cmd_valid ? head.rs1 : '0;
    assign cmd_rs2   = cmd_valid ? head.rs2 : '0;
    assign cmd_imm   = cmd_valid ? head.imm : '0;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept a push.
    always_comb begin
        op_in      = la_data_in[OP_LSB +: 3];
        detect     = armed && !la_oenb[127] && (la_data_in[127] != strb_q);
        pop        = cmd_valid && cmd_ready;
        push_req   = detect && (op_in >= 3'd1) && (op_in <= 3'd4);
        push       = push_req && ((count < CNT_W'(FIFO_DEPTH)) || pop);
        clr        = detect && (op_in == 3'd5);
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
        ovf_next   = clr ? 1'b0 : (ovf_sticky || (push_req && !push));
        ill_next   = clr ? 1'b0 : (ill_sticky || (detect && (op_in >= 3'd6)));
        issue_next = issue_cnt + (pop ? 16'd1 : 16'd0);
        status_next        = '0;
        status_next[3:0]   = 4'(count_next);
        status_next[4]     = (count_next == CNT_W'(FIFO_DEPTH));
        status_next[5]     = (count_next == '0);
        status_next[6]     = ovf_next;
        status_next[7]     = ill_next;
        status_next[23:8]  = issue_next;
    end

    // armed stays low for the first cycle after reset so a strobe already high is not taken as a toggle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            strb_q      <= 1'b0;
            armed       <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            ovf_sticky  <= 1'b0;
            ill_sticky  <= 1'b0;
            issue_cnt   <= '0;
            la_data_out <= '0;
        end else begin
            strb_q      <= la_data_in[127];
            armed       <= 1'b1;
            count       <= count_next;
            ovf_sticky  <= ovf_next;
            ill_sticky  <= ill_next;
            issue_cnt   <= issue_next;
            la_data_out <= status_next;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem[wr_ptr] <= new_entry;
        end
    end

endmodule

// File: tb/tb_datapath_cmd_sequencer.sv
// Directed self-checking bench for datapath_cmd_sequencer.
module tb_datapath_cmd_sequencer;

    logic         wb_clk_i;
    logic         wb_rst_ni;
    logic [127:0] la_data_in;
    logic [127:0] la_oenb;
    logic [127:0] la_data_out;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [4:0]   cmd_rd;
    logic [4:0]   cmd_rs1;
    logic [4:0]   cmd_rs2;
    logic [31:0]  cmd_imm;

    int checks   = 0;
    int failures = 0;
    int exp_issue = 0;

    datapath_cmd_sequencer dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_ni  (wb_rst_ni),
        .la_data_in (la_data_in),
        .la_oenb    (la_oenb),
        .la_data_out(la_data_out),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_rd     (cmd_rd),
        .cmd_rs1    (cmd_rs1),
        .cmd_rs2    (cmd_rs2),
        .cmd_imm    (cmd_imm)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    task tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    // Loads the command fields and flips the strobe, then lets one edge pass.
    task send(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
              input logic [4:0] rs2, input logic [31:0] imm);
        la_data_in[31:0]  = imm;
        la_data_in[36:32] = rd;
        la_data_in[41:37] = rs1;
        la_data_in[46:42] = rs2;
        la_data_in[49:47] = op;
        la_data_in[127]   = ~la_data_in[127];
        tick();
    endtask

    task test_reset();
        wb_rst_ni  = 1'b0;
        la_data_in = '0;
        la_data_in[127] = 1'b1;
        la_oenb    = '0;
        cmd_ready  = 1'b0;
        tick();
        tick();
        checks++;
        if (la_data_out !== 128'h0) begin
            failures++;
            $display("[TB] FAIL reset_status_in_reset: got %h expected 0", la_data_out);
        end
        wb_rst_ni = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (cmd_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_no_push: cmd_valid got %b expected 0", cmd_valid);
        end
        checks++;
        if (la_data_out !== 128'h20) begin
            failures++;
            $display("[TB] FAIL reset_status: got %h expected 20", la_data_out);
        end
    endtask

    task test_single_issue();
        cmd_ready = 1'b1;
        send(3'd3, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF);
        checks++;
        if ({cmd_valid, cmd_op, cmd_rd, cmd_imm} !== {1'b1, 3'd3, 5'd5, 32'hDEADBEEF}) begin
            failures++;
            $display("[TB] FAIL single_head: got v=%b op=%0d rd=%0d imm=%h expected v=1 op=3 rd=5 imm=deadbeef",
                     cmd_valid, cmd_op, cmd_rd, cmd_imm);
        end
        tick();
        exp_issue++;
        checks++;
        if (cmd_valid !== 1'b0 || cmd_imm !== 32'h0) begin
            failures++;
            $display("[TB] FAIL single_pulse: got v=%b imm=%h expected v=0 imm=0", cmd_valid, cmd_imm);
        end
        checks++;
        if (la_data_out !== 128'h120) begin
            failures++;
            $display("[TB] FAIL single_status: got %h expected 120", la_data_out);
        end
    endtask

    task test_overflow();
        cmd_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send(3'd1, 5'(k + 1), 5'(k), 5'(k + 2), 32'(k));
        end
        checks++;
        if (la_data_out !== 128'h154) begin
            failures++;
            $display("[TB] FAIL overflow_status: got %h expected 154", la_data_out);
        end
        checks++;
        if (cmd_valid !== 1'b1 || cmd_rd !== 5'd1) begin
            failures++;
            $display("[TB] FAIL overflow_head_stable: got v=%b rd=%0d expected v=1 rd=1", cmd_valid, cmd_rd);
        end
        cmd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm} !==
                {1'b1, 3'd1, 5'(k + 1), 5'(k), 5'(k + 2), 32'(k)}) begin
                failures++;
                $display("[TB] FAIL drain_order_%0d: got v=%b rd=%0d rs1=%0d rs2=%0d imm=%h expected rd=%0d",
                         k, cmd_valid, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, k + 1);
            end
            tick();
            exp_issue++;
        end
        checks++;
        if (la_data_out !== 128'h560) begin
            failures++;
            $display("[TB] FAIL drain_status: got %h expected 560", la_data_out);
        end
    endtask

    task test_full_push_pop();
        cmd_ready = 1'b0;
        send(3'd5, 5'd0, 5'd0, 5'd0, 32'h0);
        tick();
        checks++;
        if (la_data_out[6] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clear_overflow: got %b expected 0", la_data_out[6]);
        end
        for (int k = 0; k < 4; k++) begin
            send(3'd2, 5'(10 + k), 5'd1, 5'd0, 32'(100 + k));
        end
        cmd_ready = 1'b1;
        send(3'd2, 5'd14, 5'd1, 5'd0, 32'd104);
        exp_issue++;
        checks++;
        if (la_data_out[7:0] !== 8'h14) begin
            failures++;
            $display("[TB] FAIL full_push_pop_status: got %h expected 14", la_data_out[7:0]);
        end
        for (int k = 1; k < 5; k++) begin
            checks++;
            if (cmd_valid !== 1'b1 || cmd_rd !== 5'(10 + k) || cmd_imm !== 32'(100 + k)) begin
                failures++;
                $display("[TB] FAIL full_push_pop_order_%0d: got v=%b rd=%0d imm=%0d expected rd=%0d imm=%0d",
                         k, cmd_valid, cmd_rd, cmd_imm, 10 + k, 100 + k);
            end
            tick();
            exp_issue++;
        end
        checks++;
        if (la_data_out[23:8] !== 16'(exp_issue) || la_data_out[5] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL full_push_pop_counter: got %h expected counter %0d empty", la_data_out, exp_issue);
        end
    endtask

    task test_illegal_clear();
        cmd_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send(3'd4, 5'd0, 5'(k), 5'd0, 32'h0);
        end
        send(3'd7, 5'd3, 5'd3, 5'd3, 32'h0);
        checks++;
        if (la_data_out[7:0] !== 8'hD4) begin
            failures++;
            $display("[TB] FAIL illegal_set: got %h expected d4", la_data_out[7:0]);
        end
        send(3'd5, 5'd0, 5'd0, 5'd0, 32'h0);
        checks++;
        if (la_data_out[7:0] !== 8'h14) begin
            failures++;
            $display("[TB] FAIL clr_status: got %h expected 14", la_data_out[7:0]);
        end
        cmd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_issue++;
        end
        checks++;
        if (la_data_out[7:0] !== 8'h20) begin
            failures++;
            $display("[TB] FAIL illegal_nothing_queued: got %h expected 20", la_data_out[7:0]);
        end
        send(3'd0, 5'd1, 5'd1, 5'd1, 32'h1);
        tick();
        checks++;
        if (cmd_valid !== 1'b0 || la_data_out[7:0] !== 8'h20) begin
            failures++;
            $display("[TB] FAIL nop_dropped: got v=%b status=%h expected v=0 status=20", cmd_valid, la_data_out[7:0]);
        end
    endtask

    task test_oenb();
        cmd_ready = 1'b0;
        la_oenb[127] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send(3'd1, 5'd2, 5'd2, 5'd2, 32'h0);
        end
        la_oenb[127] = 1'b0;
        tick();
        tick();
        checks++;
        if (cmd_valid !== 1'b0 || la_data_out[3:0] !== 4'd0) begin
            failures++;
            $display("[TB] FAIL oenb_ignored: got v=%b count=%0d expected v=0 count=0", cmd_valid, la_data_out[3:0]);
        end
    endtask

    task test_reset_mid();
        cmd_ready = 1'b0;
        send(3'd1, 5'd7, 5'd0, 5'd0, 32'h0);
        send(3'd1, 5'd8, 5'd0, 5'd0, 32'h0);
        #2;
        wb_rst_ni = 1'b0;
        #1;
        checks++;
        if (cmd_valid !== 1'b0 || la_data_out !== 128'h0) begin
            failures++;
            $display("[TB] FAIL async_reset: got v=%b status=%h expected v=0 status=0", cmd_valid, la_data_out);
        end
        tick();
        wb_rst_ni = 1'b1;
        exp_issue = 0;
        tick();
        tick();
        tick();
        checks++;
        if (cmd_valid !== 1'b0 || la_data_out !== 128'h20) begin
            failures++;
            $display("[TB] FAIL reset_mid_no_redetect: got v=%b status=%h expected v=0 status=20", cmd_valid, la_data_out);
        end
    endtask

    task test_counter_wrap();
        cmd_ready = 1'b1;
        for (int k = 0; k < 65535; k++) begin
            send(3'd1, 5'd1, 5'd2, 5'd3, 32'h0);
        end
        tick();
        checks++;
        if (la_data_out[23:8] !== 16'hFFFF || cmd_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL counter_ffff: got %h v=%b expected ffff v=0", la_data_out[23:8], cmd_valid);
        end
        send(3'd3, 5'd9, 5'd0, 5'd0, 32'h1);
        tick();
        checks++;
        if (la_data_out[23:8] !== 16'h0000 || la_data_out[5] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL counter_wrap: got %h expected counter 0000 empty", la_data_out);
        end
    endtask

    initial begin
        test_reset();
        test_single_issue();
        test_overflow();
        test_full_push_pop();
        test_illegal_clear();
        test_oenb();
        test_reset_mid();
        test_counter_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
